// File: rtl/noc_alloc_pkg.sv
// noc_alloc_pkg: shared types and defaults for the NoC output-port allocator.
//   alloc_state_t    : allocator FSM states (IDLE / LOCK / RELEASE)
//   ALLOC_RN_DEF     : default number of requesting input buffers
//   ALLOC_TO_CYC_DEF : default idle-lock timeout in cycles
//   ALLOC_TW_DEF     : default timeout counter width
package noc_alloc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOCK,
        RELEASE
    } alloc_state_t;

    localparam int ALLOC_RN_DEF     = 4;
    localparam int ALLOC_TO_CYC_DEF = 64;
    localparam int ALLOC_TW_DEF     = 6;

endpackage

// File: rtl/outport_alloc_rr_pick.sv
// rr_pick: combinational round-robin search.
//   req  [RN-1:0] : request vector
//   ptr  [PW-1:0] : index of the last granted input
//   pick [RN-1:0] : one-hot first set bit searching upward from ptr+1 mod RN,
//                   all-zero when req is zero
module rr_pick
    import noc_alloc_pkg::*;
#(
    parameter int RN = ALLOC_RN_DEF,
    parameter int PW = (RN > 1) ? $clog2(RN) : 1
) (
    input  logic [RN-1:0] req,
    input  logic [PW-1:0] ptr,
    output logic [RN-1:0] pick
);

    localparam int unsigned RNU = RN;

    int unsigned idx;
    logic        found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 1; i <= RNU; i++) begin
            idx = (32'(ptr) + i) % RNU;
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/outport_alloc.sv
// outport_alloc: round-robin wormhole allocator for one NoC output port.
//   clk      : clock
//   rst      : synchronous active-high reset
//   req      : per-input level route requests
//   flit_vld : a flit crosses this port this cycle
//   flit_eof : crossing flit is a tail flit (qualified by flit_vld)
//   gnt      : registered one-hot grant
//   ra       : registered route ack (|gnt)
//   busy     : registered, high in LOCK and RELEASE
//   timeout  : one-cycle pulse on a forced release
// Optional feature macro ALLOC_TIMEOUT_EN: idle-lock timeout counter. Without
// it a lock ends only by tail flit or request abort and timeout stays 0.
module outport_alloc
    import noc_alloc_pkg::*;
#(
    parameter int RN     = ALLOC_RN_DEF,
    parameter int TO_CYC = ALLOC_TO_CYC_DEF,
    parameter int TW     = ALLOC_TW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [RN-1:0] req,
    input  logic          flit_vld,
    input  logic          flit_eof,
    output logic [RN-1:0] gnt,
    output logic          ra,
    output logic          busy,
    output logic          timeout
);

    localparam int PW = (RN > 1) ? $clog2(RN) : 1;

    if (TO_CYC > (1 << TW) || TO_CYC < 1) begin : g_bad_cfg
        $error("outport_alloc: TO_CYC must be in 1..2**TW");
    end

    alloc_state_t  state, state_n;
    logic [RN-1:0] gnt_q, gnt_n;
    logic [PW-1:0] ptr_q, ptr_n;
    logic [PW-1:0] gidx_q, gidx_n;
    logic          to_n;
    logic          to_hit;
    logic [RN-1:0] pick;
    logic [PW-1:0] pick_idx;

    rr_pick #(.RN(RN), .PW(PW)) u_rr_pick (
        .req  (req),
        .ptr  (ptr_q),
        .pick (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < RN; i++) begin
            if (pick[i]) pick_idx = PW'(i);
        end
    end

`ifdef ALLOC_TIMEOUT_EN
    logic [TW-1:0] cnt;

    // Counter sits at zero outside LOCK, which gives the clear on LOCK entry.
    always_ff @(posedge clk) begin
        if (rst || state != LOCK || flit_vld) cnt <= '0;
        else                                   cnt <= cnt + 1'b1;
    end

    assign to_hit = (state == LOCK) && !flit_vld && (cnt == TW'(TO_CYC - 1));
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_n = state;
        gnt_n   = gnt_q;
        ptr_n   = ptr_q;
        gidx_n  = gidx_q;
        to_n    = 1'b0;
        case (state)
            IDLE: begin
                gnt_n = '0;
                if (|req) begin
                    gnt_n   = pick;
                    gidx_n  = pick_idx;
                    state_n = LOCK;
                end
            end
            LOCK: begin
                // Tail flit outranks abort, abort outranks timeout.
                if (flit_vld && flit_eof) begin
                    state_n = RELEASE;
                    gnt_n   = '0;
                    ptr_n   = gidx_q;
                end else if (!req[gidx_q]) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    ptr_n   = gidx_q;
                end else if (to_hit) begin
                    state_n = RELEASE;
                    gnt_n   = '0;
                    ptr_n   = gidx_q;
                    to_n    = 1'b1;
                end
            end
            RELEASE: begin
                // ptr already holds the released input; wait for its request to drop.
                gnt_n = '0;
                if (!req[ptr_q]) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= PW'(RN - 1);
            gidx_q  <= '0;
            ra      <= 1'b0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            gnt_q   <= gnt_n;
            ptr_q   <= ptr_n;
            gidx_q  <= gidx_n;
            ra      <= |gnt_n;
            busy    <= (state_n != IDLE);
            timeout <= to_n;
        end
    end

    assign gnt = gnt_q;

endmodule

// File: tb/tb_outport_alloc.sv
module tb_outport_alloc;

`ifdef ALLOC_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 64;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       flit_vld;
    logic       flit_eof;
    logic [3:0] gnt;
    logic       ra;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    outport_alloc #(.RN(4), .TO_CYC(TO), .TW(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .flit_vld (flit_vld),
        .flit_eof (flit_eof),
        .gnt      (gnt),
        .ra       (ra),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic b, input logic t);
        check({tag, ".gnt"}, 32'(gnt), 32'(g));
        check({tag, ".ra"}, 32'(ra), 32'(|g));
        check({tag, ".busy"}, 32'(busy), 32'(b));
        check({tag, ".timeout"}, 32'(timeout), 32'(t));
    endtask

    initial begin
        rst = 1'b1; req = '0; flit_vld = 1'b0; flit_eof = 1'b0;
        step(); step();
        chk_out("reset", 4'b0000, 1'b0, 1'b0);

        // First grant goes to input 0 one cycle after request.
        rst = 1'b0; req = 4'b0101;
        step();
        chk_out("first_grant", 4'b0001, 1'b1, 1'b0);

        // Three body flits keep the grant.
        flit_vld = 1'b1; flit_eof = 1'b0;
        step(); step(); step();
        chk_out("body_flits", 4'b0001, 1'b1, 1'b0);
        flit_eof = 1'b1;
        step();
        flit_vld = 1'b0; flit_eof = 1'b0;
        chk_out("eof_release", 4'b0000, 1'b1, 1'b0);
        step();
        chk_out("release_hold", 4'b0000, 1'b1, 1'b0);
        req = 4'b0100;
        step();
        chk_out("back_idle", 4'b0000, 1'b0, 1'b0);
        step();
        chk_out("rr_grant2", 4'b0100, 1'b1, 1'b0);

        // Abort: req[2] drops; ptr becomes 2 so input 0 beats input 1 next.
        req = 4'b0011;
        step();
        chk_out("abort", 4'b0000, 1'b0, 1'b0);
        step();
        chk_out("after_abort", 4'b0001, 1'b1, 1'b0);

        // New requests while locked are ignored.
        req = 4'b0111;
        step();
        chk_out("ignore_new_req", 4'b0001, 1'b1, 1'b0);

        // Tail and new request together: no grant on IDLE re-entry edge.
        flit_vld = 1'b1; flit_eof = 1'b1; req = 4'b0011;
        step();
        flit_vld = 1'b0; flit_eof = 1'b0;
        chk_out("eof2", 4'b0000, 1'b1, 1'b0);
        req = 4'b0010;
        step();
        chk_out("idle_no_early", 4'b0000, 1'b0, 1'b0);
        step();
        chk_out("grant_in1", 4'b0010, 1'b1, 1'b0);

        // Single requester, two frames with one RELEASE gap.
        flit_vld = 1'b1; flit_eof = 1'b1;
        step();
        flit_vld = 1'b0; flit_eof = 1'b0;
        chk_out("single_rel", 4'b0000, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        chk_out("single_idle", 4'b0000, 1'b0, 1'b0);
        req = 4'b0010;
        step();
        chk_out("single_regrant", 4'b0010, 1'b1, 1'b0);

`ifdef ALLOC_TIMEOUT_EN
        repeat (7) step();
        chk_out("pre_timeout", 4'b0010, 1'b1, 1'b0);
        step();
        chk_out("timeout_pulse", 4'b0000, 1'b1, 1'b1);
        step();
        chk_out("timeout_once", 4'b0000, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        chk_out("to_idle", 4'b0000, 1'b0, 1'b0);
`else
        repeat (100) step();
        chk_out("hold_100", 4'b0010, 1'b1, 1'b0);
        flit_vld = 1'b1; flit_eof = 1'b1;
        step();
        chk_out("hold_eof", 4'b0000, 1'b1, 1'b0);
        flit_vld = 1'b0; flit_eof = 1'b0; req = 4'b0000;
        step();
        chk_out("hold_idle", 4'b0000, 1'b0, 1'b0);
`endif

        // Flits outside LOCK are ignored.
        flit_vld = 1'b1; flit_eof = 1'b1;
        step();
        flit_vld = 1'b0; flit_eof = 1'b0;
        chk_out("flit_in_idle", 4'b0000, 1'b0, 1'b0);

        // Reset while locked drops the grant; input 0 wins afterwards.
        req = 4'b1111;
        step();
        chk_out("lock_before_rst", 4'b0100, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        chk_out("rst_mid_frame", 4'b0000, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        chk_out("after_rst", 4'b0001, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
